// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and load-use hazard detection
// Tracks per-stage/per-lane destination tags, picks the youngest producer per source, stalls on early loads.
module fwd_hazard_unit #(
  parameter int LANES    = 2,
  parameter int SRCS     = 3,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2,
  parameter int DW       = 16,
  parameter int RW       = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES-1:0]            issue_valid,
  input  logic [LANES-1:0]            issue_write,
  input  logic [LANES-1:0]            issue_load,
  input  logic [LANES*RW-1:0]         issue_wnum,
  input  logic [LANES*SRCS*RW-1:0]    src_num,
  input  logic [LANES*SRCS*DW-1:0]    src_regdata,
  input  logic [DEPTH*LANES*DW-1:0]   stage_data,
  input  logic                        flush,
  output logic [LANES*SRCS*DW-1:0]    fwd_data,
  output logic                        stall,
  output logic [LANES-1:0]            wb_write,
  output logic [LANES*RW-1:0]         wb_num,
  output logic [15:0]                 stall_cnt
);

  // Array index 0 holds stage 1 (execute result), index DEPTH-1 holds writeback.
  logic [DEPTH-1:0][LANES-1:0]         r_write;
  logic [DEPTH-1:0][LANES-1:0]         r_load;
  logic [DEPTH-1:0][LANES-1:0][RW-1:0] r_num;
  logic [15:0]                         r_stall_cnt;
  logic                                w_stall_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write     <= '0;
      r_load      <= '0;
      r_num       <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        r_write[0][l] <= issue_valid[l] & issue_write[l] & ~stall & ~flush;
        r_load[0][l]  <= issue_load[l];
        r_num[0][l]   <= issue_wnum[l*RW +: RW];
      end
      for (int s = 1; s < DEPTH; s++) begin
        r_write[s] <= flush ? '0 : r_write[s-1];
        r_load[s]  <= r_load[s-1];
        r_num[s]   <= r_num[s-1];
      end
      if (stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  always_comb begin : fwd_select
    logic [RW-1:0] w_sn;
    logic [DW-1:0] w_val;
    logic          w_late;
    fwd_data    = '0;
    w_stall_raw = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < SRCS; j++) begin
        w_sn   = src_num[(l*SRCS+j)*RW +: RW];
        w_val  = src_regdata[(l*SRCS+j)*DW +: DW];
        w_late = 1'b0;
        // Oldest-to-youngest, low-to-high lane: the last hit is the winner.
        for (int s = DEPTH-1; s >= 0; s--) begin
          for (int k = 0; k < LANES; k++) begin
            if (r_write[s][k] && (r_num[s][k] == w_sn)) begin
              w_val  = stage_data[(s*LANES+k)*DW +: DW];
              w_late = r_load[s][k] && ((s + 1) < LOAD_RDY);
            end
          end
        end
        fwd_data[(l*SRCS+j)*DW +: DW] = w_val;
        if (issue_valid[l] && w_late) begin
          w_stall_raw = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wb_num = '0;
    for (int l = 0; l < LANES; l++) begin
      wb_num[l*RW +: RW] = r_num[DEPTH-1][l];
    end
  end

  assign stall     = w_stall_raw & ~flush;
  assign wb_write  = r_write[DEPTH-1];
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed-vector bench for fwd_hazard_unit
module tb_fwd_hazard_unit;
  localparam int L = 2, S = 3, D = 3, W = 16, R = 3;
  localparam int SD = 32;

  logic               clk = 1'b0;
  logic               rst, rst_s;
  logic [L-1:0]       issue_valid, issue_write, issue_load;
  logic [L*R-1:0]     issue_wnum;
  logic [L*S*R-1:0]   src_num;
  logic [L*S*W-1:0]   src_regdata;
  logic [D*L*W-1:0]   stage_data;
  logic               flush;
  logic [L*S*W-1:0]   fwd_data;
  logic               stall;
  logic [L-1:0]       wb_write;
  logic [L*R-1:0]     wb_num;
  logic [15:0]        stall_cnt;

  logic [W-1:0]       s_fwd;
  logic               s_stall;
  logic [0:0]         s_wb_write;
  logic [R-1:0]       s_wb_num;
  logic [15:0]        s_stall_cnt;
  logic [SD*W-1:0]    s_stage_data = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.LANES(L), .SRCS(S), .DEPTH(D), .LOAD_RDY(2), .DW(W), .RW(R)) u_dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_write(issue_write),
    .issue_load(issue_load), .issue_wnum(issue_wnum), .src_num(src_num),
    .src_regdata(src_regdata), .stage_data(stage_data), .flush(flush),
    .fwd_data(fwd_data), .stall(stall), .wb_write(wb_write), .wb_num(wb_num),
    .stall_cnt(stall_cnt)
  );

  // Deep single-lane instance: a perpetual load-use chain stalls 31 of every 32 cycles.
  fwd_hazard_unit #(.LANES(1), .SRCS(1), .DEPTH(SD), .LOAD_RDY(SD), .DW(W), .RW(R)) u_sat (
    .clk(clk), .rst(rst_s), .issue_valid(1'b1), .issue_write(1'b1),
    .issue_load(1'b1), .issue_wnum(3'd5), .src_num(3'd5),
    .src_regdata(16'h0000), .stage_data(s_stage_data), .flush(1'b0),
    .fwd_data(s_fwd), .stall(s_stall), .wb_write(s_wb_write), .wb_num(s_wb_num),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rd(input int l, input int j);
    return 16'hF000 | 16'(l*16 + j);
  endfunction

  function automatic logic [W-1:0] fwd(input int l, input int j);
    return fwd_data[(l*S+j)*W +: W];
  endfunction

  task automatic set_src(input int l, input int j, input logic [R-1:0] n);
    src_num[(l*S+j)*R +: R] = n;
  endtask

  task automatic set_wnum(input int l, input logic [R-1:0] n);
    issue_wnum[l*R +: R] = n;
  endtask

  task automatic set_sd(input int s, input int l, input logic [W-1:0] v);
    stage_data[((s-1)*L+l)*W +: W] = v;
  endtask

  task automatic idle();
    issue_valid = '0; issue_write = '0; issue_load = '0;
    issue_wnum = '0; src_num = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rst_s = 1'b0;
    idle();
    stage_data = '0;
    for (int l = 0; l < L; l++)
      for (int j = 0; j < S; j++)
        src_regdata[(l*S+j)*W +: W] = rd(l, j);
    #2;
    check("rst_wb_write", wb_write, 0);
    check("rst_stall", stall, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_fwd_regdata", fwd(0, 0), rd(0, 0));
    tick();
    rst = 1'b1;

    // ALU chain: lane1 writes R3, lane0 consumes it
    issue_valid = 2'b10; issue_write = 2'b10; set_wnum(1, 3);
    tick();
    idle(); issue_valid = 2'b01; set_src(0, 0, 3); set_sd(1, 1, 16'h00AA);
    #1;
    check("alu_fwd_s1", fwd(0, 0), 16'h00AA);
    check("alu_stall", stall, 0);
    check("alu_other_src", fwd(0, 1), rd(0, 1));
    tick();
    set_sd(2, 1, 16'h0BBB);
    #1;
    check("alu_fwd_s2", fwd(0, 0), 16'h0BBB);
    tick();
    check("alu_wb_write", wb_write, 2'b10);
    check("alu_wb_num", wb_num[5:3], 3);
    tick();
    check("alu_wb_retired", wb_write, 2'b00);

    // Priority: higher lane within a stage, then younger stage over older
    idle(); issue_valid = 2'b11; issue_write = 2'b11; set_wnum(0, 2); set_wnum(1, 2);
    tick();
    idle(); issue_valid = 2'b01; issue_write = 2'b01; set_wnum(0, 2); set_src(0, 0, 2);
    set_sd(1, 0, 16'h1111); set_sd(1, 1, 16'h2222);
    #1;
    check("prio_lane", fwd(0, 0), 16'h2222);
    tick();
    idle(); set_src(1, 2, 2);
    set_sd(1, 0, 16'h3333); set_sd(2, 0, 16'h4444); set_sd(2, 1, 16'h5555);
    #1;
    check("prio_stage", fwd(1, 2), 16'h3333);
    repeat (3) tick();

    // Load-use: lane0 loads R5, lane1 reads it next cycle
    idle(); issue_valid = 2'b01; issue_write = 2'b01; issue_load = 2'b01; set_wnum(0, 5);
    tick();
    idle(); set_src(1, 1, 5); set_sd(2, 0, 16'h0DEF);
    #1;
    check("lu_invalid_lane", stall, 0);
    issue_valid = 2'b10;
    #1;
    check("lu_stall", stall, 1);
    check("lu_cnt_before", stall_cnt, 0);
    tick();
    check("lu_released", stall, 0);
    check("lu_cnt", stall_cnt, 1);
    check("lu_fwd_s2", fwd(1, 1), 16'h0DEF);

    // Shadowing: younger non-load in the same stage hides the load
    idle(); issue_valid = 2'b11; issue_write = 2'b11; issue_load = 2'b01;
    set_wnum(0, 6); set_wnum(1, 6);
    tick();
    idle(); issue_valid = 2'b01; set_src(0, 0, 6); set_sd(1, 1, 16'h0666);
    #1;
    check("shadow_stall", stall, 0);
    check("shadow_fwd", fwd(0, 0), 16'h0666);
    idle(); issue_valid = 2'b11; issue_write = 2'b11; issue_load = 2'b10;
    set_wnum(0, 6); set_wnum(1, 6);
    tick();
    idle(); issue_valid = 2'b01; set_src(0, 0, 6);
    #1;
    check("shadow_rev_stall", stall, 1);
    tick();
    check("shadow_rev_cnt", stall_cnt, 2);
    check("shadow_rev_release", stall, 0);
    idle();
    repeat (3) tick();

    // Flush with three writes in flight
    idle(); issue_valid = 2'b01; issue_write = 2'b01; set_wnum(0, 1);
    tick();
    idle(); issue_valid = 2'b10; issue_write = 2'b10; set_wnum(1, 2);
    tick();
    idle(); issue_valid = 2'b01; issue_write = 2'b01; issue_load = 2'b01; set_wnum(0, 4);
    tick();
    idle(); flush = 1'b1; issue_valid = 2'b11; issue_write = 2'b10; set_wnum(1, 3);
    set_src(0, 0, 4);
    #1;
    check("flush_no_stall", stall, 0);
    check("flush_wb_live", wb_write, 2'b01);
    check("flush_wb_num", wb_num[2:0], 1);
    tick();
    idle(); set_src(0, 0, 4); set_src(1, 0, 2); set_src(1, 2, 3);
    #1;
    check("flush_wb_cleared", wb_write, 2'b00);
    check("flush_src_r4", fwd(0, 0), rd(0, 0));
    check("flush_src_r2", fwd(1, 0), rd(1, 0));
    check("flush_src_r3", fwd(1, 2), rd(1, 2));
    check("flush_cnt", stall_cnt, 2);
    tick();
    check("flush_wb_cleared2", wb_write, 2'b00);
    tick();
    check("flush_wb_cleared3", wb_write, 2'b00);

    // Asynchronous reset in the middle of a stall
    idle(); issue_valid = 2'b01; issue_write = 2'b01; set_wnum(0, 1);
    tick();
    idle();
    tick();
    issue_valid = 2'b01; issue_write = 2'b01; issue_load = 2'b01; set_wnum(0, 5);
    tick();
    idle(); issue_valid = 2'b10; set_src(1, 0, 5);
    #1;
    check("ar_pre_stall", stall, 1);
    check("ar_pre_wb", wb_write, 2'b01);
    #2;
    rst = 1'b0;
    #1;
    check("ar_wb_write", wb_write, 2'b00);
    check("ar_stall", stall, 0);
    check("ar_stall_cnt", stall_cnt, 0);
    tick();
    idle(); issue_valid = 2'b01; issue_write = 2'b01; set_wnum(0, 6);
    rst = 1'b1;
    tick();
    idle(); issue_valid = 2'b10; set_src(1, 0, 6); set_sd(1, 0, 16'h0606);
    #1;
    check("ar_resume_fwd", fwd(1, 0), 16'h0606);
    check("ar_resume_stall", stall, 0);
    check("ar_resume_cnt", stall_cnt, 0);
    idle();

    // Counter saturation on the deep instance
    rst_s = 1'b1;
    repeat (64) tick();
    check("sat_cnt_64", s_stall_cnt, 62);
    repeat (68000) tick();
    check("sat_cnt_max", s_stall_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
